// File: rtl/scv_pkg.sv
// Shared SCV definitions: cartridge loader FSM states, ROM capacity and HPS ioctl indices.
package scv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SIZE = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } cart_state_e;

  localparam int CART_MAX_BYTES = 1 << 17;

  localparam logic [7:0] IOCTL_IDX_BOOT = 8'd0;
  localparam logic [7:0] IOCTL_IDX_CART = 8'd1;

endpackage

// File: rtl/cart_loader.sv
// Turns the HPS ioctl byte stream into cart_rom init writes, sizes the image to a
// power-of-two window, pads the tail with FILL_BYTE and flags when the cartridge is usable.
module cart_loader
  import scv_pkg::*;
#(
  parameter logic [7:0] CART_INDEX = IOCTL_IDX_CART,
  parameter int         MIN_AW     = 11,
  parameter int         MAX_AW     = 17,
  parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
  input  logic        CLK,
  input  logic        RESB,
  input  logic        IOCTL_DOWNLOAD,
  input  logic [7:0]  IOCTL_INDEX,
  input  logic        IOCTL_WR,
  input  logic [7:0]  IOCTL_DATA,
  output logic        IOCTL_WAIT,
  output logic [16:0] INIT_ADDR,
  output logic [7:0]  INIT_DATA,
  output logic        INIT_VALID,
  output logic [4:0]  CFG_AW,
  output logic        CART_READY,
  output logic        CART_ERR
);

  localparam logic [17:0] CAP = 18'd1 << MAX_AW;

  cart_state_e state_q, state_d;
  logic        dl_q;
  logic [17:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [4:0]  aw_q, aw_d;
  logic [4:0]  cfg_aw_q, cfg_aw_d;
  logic [17:0] ptr_q, ptr_d;
  logic [16:0] init_addr_q, init_addr_d;
  logic [7:0]  init_data_q, init_data_d;
  logic        init_valid_q, init_valid_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        wait_q, wait_d;

  logic        dl_rise, dl_fall, start;
  logic [17:0] aw_pow, fill_limit;

  assign dl_rise    = IOCTL_DOWNLOAD & ~dl_q;
  assign dl_fall    = ~IOCTL_DOWNLOAD & dl_q;
  assign start      = dl_rise && (IOCTL_INDEX == CART_INDEX);
  assign aw_pow     = 18'd1 << aw_q;
  assign fill_limit = 18'd1 << cfg_aw_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    aw_d         = aw_q;
    cfg_aw_d     = cfg_aw_q;
    ptr_d        = ptr_q;
    init_addr_d  = init_addr_q;
    init_data_d  = init_data_q;
    init_valid_d = 1'b0;
    ready_d      = ready_q;
    err_d        = err_q;
    wait_d       = wait_q;

    case (state_q)
      ST_LOAD: begin
        // A write coinciding with the download falling edge still lands.
        if (IOCTL_WR) begin
          if (count_q == CAP) begin
            ovf_d = 1'b1;
          end else begin
            init_valid_d = 1'b1;
            init_addr_d  = count_q[16:0];
            init_data_d  = IOCTL_DATA;
            count_d      = count_q + 18'd1;
          end
        end
        if (dl_fall) begin
          state_d = ST_SIZE;
          wait_d  = 1'b1;
          aw_d    = 5'(MIN_AW);
        end
      end
      ST_SIZE: begin
        if (aw_pow >= count_q || aw_q == 5'(MAX_AW)) begin
          cfg_aw_d = aw_q;
          ptr_d    = count_q;
          if (count_q == 18'd0 || ovf_q) begin
            err_d   = 1'b1;
            wait_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          aw_d = aw_q + 5'd1;
        end
      end
      ST_FILL: begin
        if (ptr_q < fill_limit) begin
          init_valid_d = 1'b1;
          init_addr_d  = ptr_q[16:0];
          init_data_d  = FILL_BYTE;
          ptr_d        = ptr_q + 18'd1;
        end else begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          wait_d  = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A matching download start wins from any state, abandoning whatever was in flight.
    if (start) begin
      state_d      = ST_LOAD;
      count_d      = 18'd0;
      ovf_d        = 1'b0;
      ready_d      = 1'b0;
      err_d        = 1'b0;
      wait_d       = 1'b0;
      init_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q      <= ST_IDLE;
      dl_q         <= 1'b0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      aw_q         <= 5'(MIN_AW);
      cfg_aw_q     <= 5'(MIN_AW);
      ptr_q        <= '0;
      init_addr_q  <= '0;
      init_data_q  <= '0;
      init_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      wait_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= IOCTL_DOWNLOAD;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      aw_q         <= aw_d;
      cfg_aw_q     <= cfg_aw_d;
      ptr_q        <= ptr_d;
      init_addr_q  <= init_addr_d;
      init_data_q  <= init_data_d;
      init_valid_q <= init_valid_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      wait_q       <= wait_d;
    end
  end

  assign IOCTL_WAIT = wait_q;
  assign INIT_ADDR  = init_addr_q;
  assign INIT_DATA  = init_data_q;
  assign INIT_VALID = init_valid_q;
  assign CFG_AW     = cfg_aw_q;
  assign CART_READY = ready_q;
  assign CART_ERR   = err_q;

endmodule
